// File: rtl/ss_pkg.sv
// Shared definitions for the sample-window loader slice.
//   SS_DATA_W     default ROM/array word width
//   SS_ADDR_ROM   default ROM address width (must match SS_rom_addr)
//   SS_WIN_LEN    default samples per window
//   ss_ld_state_e loader sequencer states
package ss_pkg;

  localparam int unsigned SS_DATA_W   = 16;
  localparam int unsigned SS_ADDR_ROM = 16;
  localparam int unsigned SS_WIN_LEN  = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } ss_ld_state_e;

endpackage

// File: rtl/ss_loader_chksum.sv
// Running sum of loaded window samples.
//   i_clk, i_rst_n  clock, async active-low reset
//   i_clr           clear the sum (wins over i_acc)
//   i_acc           add zero-extended i_data this cycle
//   i_data          sample being written to the array
//   o_sum           current sum
module ss_loader_chksum
  import ss_pkg::*;
#(
  parameter int unsigned DATA_W = SS_DATA_W,
  parameter int unsigned SUM_W  = SS_DATA_W + SS_ADDR_ROM
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clr,
  input  logic              i_acc,
  input  logic [DATA_W-1:0] i_data,
  output logic [SUM_W-1:0]  o_sum
);

  logic [SUM_W-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (i_clr) begin
      sum_d = '0;
    end else if (i_acc) begin
      sum_d = sum_q + SUM_W'(i_data);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign o_sum = sum_q;

endmodule

// File: rtl/ss_window_loader.sv
// Loads one window of WIN_LEN samples from the synchronous sample ROM into the
// temporary sample array, driving SS_rom_addr's write enable alongside.
//   i_clk, i_rst_n  clock, async active-low reset
//   i_start         load request (sampled in IDLE only)
//   i_abort         abandon the current load, highest priority after reset
//   i_rom_data      ROM word, valid one cycle after its address
//   o_rom_we        to SS_rom_addr i_we: address advances while high, clears when low
//   o_arr_we/o_arr_waddr/o_arr_wdata  array write port
//   o_busy          high in FILL and DRAIN
//   o_done          one-cycle completion pulse
//   o_chksum        sum of written samples (only with SS_LOADER_CHKSUM_EN defined)
// Optional feature macro: SS_LOADER_CHKSUM_EN
module ss_window_loader
  import ss_pkg::*;
#(
  parameter int unsigned DATA_W   = SS_DATA_W,
  parameter int unsigned ADDR_ROM = SS_ADDR_ROM,
  parameter int unsigned WIN_LEN  = SS_WIN_LEN,
  localparam int unsigned AW      = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_start,
  input  logic                       i_abort,
  input  logic [DATA_W-1:0]          i_rom_data,
  output logic                       o_rom_we,
  output logic                       o_arr_we,
  output logic [AW-1:0]              o_arr_waddr,
  output logic [DATA_W-1:0]          o_arr_wdata,
  output logic                       o_busy,
`ifdef SS_LOADER_CHKSUM_EN
  output logic                       o_done,
  output logic [DATA_W+ADDR_ROM-1:0] o_chksum
`else
  output logic                       o_done
`endif
);

  if (WIN_LEN == 0 || longint'(WIN_LEN) > (longint'(1) << ADDR_ROM)) begin : g_win_len_check
    $error("ss_window_loader: WIN_LEN out of range for ADDR_ROM");
  end

  localparam logic [AW-1:0] FcntLast = AW'(WIN_LEN - 1);

  ss_ld_state_e  state_q, state_d;
  logic [AW-1:0] fcnt_q, fcnt_d;
  logic          vld_q, vld_d;
  logic [AW-1:0] idx_q;

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = FILL;
          fcnt_d  = '0;
        end
      end
      FILL: begin
        if (fcnt_q == FcntLast) begin
          state_d = DRAIN;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q + AW'(1);
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (i_abort) begin
      state_d = IDLE;
      fcnt_d  = '0;
    end
  end

  // Valid is killed by abort so the word in flight is never written.
  assign vld_d = (state_q == FILL) && !i_abort;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      fcnt_q  <= '0;
      vld_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      vld_q   <= vld_d;
      idx_q   <= fcnt_q;
    end
  end

  assign o_rom_we    = (state_q == FILL);
  assign o_busy      = (state_q == FILL) || (state_q == DRAIN);
  assign o_done      = (state_q == DONE);
  assign o_arr_we    = vld_q;
  assign o_arr_waddr = idx_q;
  assign o_arr_wdata = i_rom_data;

`ifdef SS_LOADER_CHKSUM_EN
  logic chk_clr;
  assign chk_clr = ((state_q == IDLE) && i_start) || i_abort;

  ss_loader_chksum #(
    .DATA_W (DATA_W),
    .SUM_W  (DATA_W + ADDR_ROM)
  ) u_chksum (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (chk_clr),
    .i_acc   (vld_q),
    .i_data  (i_rom_data),
    .o_sum   (o_chksum)
  );
`endif

endmodule

// File: tb/tb_ss_window_loader.sv
module tb_ss_window_loader;

  logic clk = 1'b0;
  logic rst_n, start, abort, rom_const;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [15:0] rom_word(input logic [15:0] a, input logic c);
    return c ? 16'hFFFF : (16'h0100 + a);
  endfunction

  // DUT0: WIN_LEN=4
  logic        rom_we0, arr_we0, busy0, done0;
  logic [1:0]  waddr0;
  logic [15:0] wdata0, addr0_q, rom0_q;
  logic [31:0] sum0;
  // DUT1: WIN_LEN=1
  logic        rom_we1, arr_we1, busy1, done1;
  logic [0:0]  waddr1;
  logic [15:0] wdata1, addr1_q, rom1_q;
  logic [31:0] sum1;

  // Models of SS_rom_addr + synchronous ROM for each DUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr0_q <= '0; rom0_q <= '0; addr1_q <= '0; rom1_q <= '0;
    end else begin
      addr0_q <= rom_we0 ? addr0_q + 16'd1 : 16'd0;
      rom0_q  <= rom_word(addr0_q, rom_const);
      addr1_q <= rom_we1 ? addr1_q + 16'd1 : 16'd0;
      rom1_q  <= rom_word(addr1_q, rom_const);
    end
  end

  ss_window_loader #(.DATA_W(16), .ADDR_ROM(16), .WIN_LEN(4)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort), .i_rom_data(rom0_q),
    .o_rom_we(rom_we0), .o_arr_we(arr_we0), .o_arr_waddr(waddr0), .o_arr_wdata(wdata0),
`ifdef SS_LOADER_CHKSUM_EN
    .o_busy(busy0), .o_done(done0), .o_chksum(sum0)
`else
    .o_busy(busy0), .o_done(done0)
`endif
  );

  ss_window_loader #(.DATA_W(16), .ADDR_ROM(16), .WIN_LEN(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort), .i_rom_data(rom1_q),
    .o_rom_we(rom_we1), .o_arr_we(arr_we1), .o_arr_waddr(waddr1), .o_arr_wdata(wdata1),
`ifdef SS_LOADER_CHKSUM_EN
    .o_busy(busy1), .o_done(done1), .o_chksum(sum1)
`else
    .o_busy(busy1), .o_done(done1)
`endif
  );

`ifndef SS_LOADER_CHKSUM_EN
  assign sum0 = '0;
  assign sum1 = '0;
`endif

  // ctl = {rom_we, arr_we, busy, done}
  localparam logic [3:0] CIdle = 4'b0000, CFill = 4'b1010, CFillW = 4'b1110,
                         CDrain = 4'b0110, CDone = 4'b0001;

  typedef struct {
    logic        start;
    logic        abort;
    logic [3:0]  ctl;
    logic [1:0]  waddr;
    logic [15:0] wdata;
    logic [31:0] sum;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic s, input logic a, input logic [3:0] c,
                     input logic [1:0] wa, input logic [15:0] wd, input logic [31:0] sm);
    vec_t v;
    v.start = s; v.abort = a; v.ctl = c; v.waddr = wa; v.wdata = wd; v.sum = sm;
    vq.push_back(v);
  endtask

  task automatic add_window(input logic hold);
    add(1'b1, 1'b0, CFill,  2'd0, 16'h0,     32'h0);
    add(hold, 1'b0, CFillW, 2'd0, 16'h0100, 32'h0);
    add(hold, 1'b0, CFillW, 2'd1, 16'h0101, 32'h0);
    add(hold, 1'b0, CFillW, 2'd2, 16'h0102, 32'h0);
    add(hold, 1'b0, CDrain, 2'd3, 16'h0103, 32'h0);
    add(hold, 1'b0, CDone,  2'd0, 16'h0,     32'h406);
    add(hold, 1'b0, CIdle,  2'd0, 16'h0,     32'h0);
  endtask

  // Pulsed start on both DUTs from IDLE; checks writes, done timing, checksums.
  task automatic run_window(input string tag, input logic [31:0] exp_sum0,
                            input logic [31:0] exp_sum1);
    int nw = 0;
    int done_cyc = 0;
    start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (arr_we0) begin
        chk({tag, "_waddr"}, {30'd0, waddr0}, nw);
        chk({tag, "_wdata"}, {16'd0, wdata0}, {16'd0, rom_word(16'(nw), rom_const)});
        nw++;
      end
      if (done0 && done_cyc == 0) begin
        done_cyc = c;
`ifdef SS_LOADER_CHKSUM_EN
        chk({tag, "_sum0"}, sum0, exp_sum0);
`endif
      end
      if (c == 1) chk({tag, "_w1_c1"}, {28'd0, rom_we1, arr_we1, busy1, done1}, {28'd0, CFill});
      if (c == 2) begin
        chk({tag, "_w1_c2"}, {28'd0, rom_we1, arr_we1, busy1, done1}, {28'd0, CDrain});
        chk({tag, "_w1_waddr"}, {31'd0, waddr1}, 32'd0);
        chk({tag, "_w1_wdata"}, {16'd0, wdata1}, {16'd0, rom_word(16'd0, rom_const)});
      end
      if (c == 3) begin
        chk({tag, "_w1_c3"}, {28'd0, rom_we1, arr_we1, busy1, done1}, {28'd0, CDone});
`ifdef SS_LOADER_CHKSUM_EN
        chk({tag, "_sum1"}, sum1, exp_sum1);
`endif
      end
    end
    chk({tag, "_nwrites"}, nw, 32'd4);
    chk({tag, "_done_cycle"}, done_cyc, 32'd6);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; rom_const = 1'b0;

    // A: single window; B: start+abort in IDLE; C: abort in 3rd FILL cycle;
    // D: start held through two windows.
    add_window(1'b0);
    add(1'b1, 1'b1, CIdle, 2'd0, 16'h0, 32'h0);
    add(1'b0, 1'b0, CIdle, 2'd0, 16'h0, 32'h0);
    add(1'b1, 1'b0, CFill,  2'd0, 16'h0,    32'h0);
    add(1'b0, 1'b0, CFillW, 2'd0, 16'h0100, 32'h0);
    add(1'b0, 1'b0, CFillW, 2'd1, 16'h0101, 32'h0);
    add(1'b0, 1'b1, CIdle,  2'd0, 16'h0,    32'h0);
    add(1'b0, 1'b0, CIdle,  2'd0, 16'h0,    32'h0);
    add(1'b0, 1'b0, CIdle,  2'd0, 16'h0,    32'h0);
    add_window(1'b1);
    add_window(1'b0);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctl0", {28'd0, rom_we0, arr_we0, busy0, done0}, 32'd0);
    chk("reset_waddr0", {30'd0, waddr0}, 32'd0);
    chk("reset_ctl1", {28'd0, rom_we1, arr_we1, busy1, done1}, 32'd0);
    chk("reset_sum0", sum0, 32'd0);
    @(negedge clk) rst_n = 1'b1;

    foreach (vq[i]) begin
      start = vq[i].start;
      abort = vq[i].abort;
      @(posedge clk); #1;
      chk($sformatf("v%0d_ctl", i), {28'd0, rom_we0, arr_we0, busy0, done0}, {28'd0, vq[i].ctl});
      if (vq[i].ctl[2]) begin
        chk($sformatf("v%0d_waddr", i), {30'd0, waddr0}, {30'd0, vq[i].waddr});
        chk($sformatf("v%0d_wdata", i), {16'd0, wdata0}, {16'd0, vq[i].wdata});
      end
`ifdef SS_LOADER_CHKSUM_EN
      if (vq[i].ctl[0]) chk($sformatf("v%0d_sum", i), sum0, vq[i].sum);
`endif
    end
    start = 1'b0; abort = 1'b0;

    // E: asynchronous reset mid-FILL, then a clean load.
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("e_midfill_we", {31'd0, arr_we0}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("e_rst_ctl0", {28'd0, rom_we0, arr_we0, busy0, done0}, 32'd0);
    chk("e_rst_waddr0", {30'd0, waddr0}, 32'd0);
    chk("e_rst_sum0", sum0, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    run_window("e", 32'h406, 32'h100);

    // F: all-ones data exercises checksum width.
    rom_const = 1'b1;
    @(posedge clk); #1;
    run_window("f", 32'h3FFFC, 32'hFFFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ss_window_loader.md
# ss_window_loader

Sequencer that loads one window of WIN_LEN samples from the synchronous sample ROM into the temporary sample array (arr_temp). It sits directly upstream of SS_rom_addr: it drives that block's i_we, receives the ROM word addressed by it, and issues the matching array writes. It signals completion to the downstream processing stage.

## Interface
- DATA_W, 16: ROM and array word width.
- ADDR_ROM, 16: ROM address width. Must match SS_rom_addr.
- WIN_LEN, 64: samples per window. Legal range is 1 ≤ WIN_LEN ≤ 2^ADDR_ROM.
- AW, $clog2(WIN_LEN) with a minimum of 1: array address width (localparam).
- i_clk  in  1  clock; all logic is on the rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_start  in  1  level-sampled load request; ignored unless in IDLE.
- i_abort  in  1  abandons the current load. Takes priority over everything except reset.
- i_rom_data  in  DATA_W  synchronous ROM read data. Valid one cycle after the address.
- o_rom_we  out  1  connects to SS_rom_addr i_we. The address advances while this is high and returns to 0 when it is low.
- o_arr_we  out  1  array write strobe.
- o_arr_waddr  out  AW  array write index.
- o_arr_wdata  out  DATA_W  array write data.
- o_busy  out  1  high in FILL and DRAIN.
- o_done  out  1  one-cycle pulse when the window is complete.
- o_chksum  out  DATA_W+ADDR_ROM  only present with SS_LOADER_CHKSUM_EN.

## Operation
- States: IDLE, FILL, DRAIN, DONE.
- IDLE → FILL on i_start. No other transition leaves IDLE.
- In FILL:
  - o_rom_we=1.
  - Fill counter fcnt runs 0..WIN_LEN-1. The ROM address presented in the k-th FILL cycle equals k.
  - FILL → DRAIN when fcnt==WIN_LEN-1.
- In DRAIN: o_rom_we=0, so the address generator returns to 0 on the next edge. Lasts one cycle, then → DONE.
- In DONE: o_done=1 for one cycle, then → IDLE.
- Array write path:
  - A one-stage valid/index pipeline delays (o_rom_we, fcnt) by one cycle to align with i_rom_data.
  - o_arr_we = delayed valid. o_arr_waddr = delayed fcnt. o_arr_wdata = i_rom_data, passed combinationally.
  - The write of element k therefore occurs one cycle after FILL cycle k. The last write (WIN_LEN-1) occurs in DRAIN.
- Abort:
  - i_abort in any state → IDLE on the next edge.
  - o_rom_we and the pipeline valid both clear on that edge, so no array write occurs after the abort edge.
  - o_done is not pulsed. A partial window remains in the array and is considered invalid.
- Simultaneous i_start and i_abort in IDLE: abort wins, state stays IDLE.
- i_start held high through DONE starts a new load from the IDLE cycle that follows. Back-to-back windows are separated by exactly the IDLE cycle.
- Every window reads ROM addresses 0..WIN_LEN-1. This follows from SS_rom_addr resetting to 0 whenever o_rom_we is low.
- WIN_LEN=1: FILL lasts one cycle, and the single write lands in DRAIN.

## Timing
- Reset values:
  - state=IDLE, fcnt=0, pipeline valid=0.
  - o_rom_we=0, o_arr_we=0, o_arr_waddr=0, o_busy=0, o_done=0, o_chksum=0.
  - o_arr_wdata reflects i_rom_data.
- Latency, with i_start sampled at edge 0:
  - FILL spans cycles 1..WIN_LEN.
  - Writes occur in cycles 2..WIN_LEN+1.
  - DRAIN is cycle WIN_LEN+1.
  - o_done is high in cycle WIN_LEN+2.
  - IDLE resumes in cycle WIN_LEN+3.
- o_rom_we, o_busy, o_done and o_arr_we are registered-state decodes only, with no combinational path from the inputs.
- Reset asserted mid-load: all outputs go to their reset values immediately (asynchronously).

## Configuration
- SS_LOADER_CHKSUM_EN defined:
  - o_chksum accumulates the zero-extended i_rom_data on every o_arr_we cycle.
  - It clears on the IDLE→FILL transition and on abort.
  - It holds its value from DONE until the next start.
  - Width is DATA_W+ADDR_ROM, so there is no overflow for any legal WIN_LEN.
- Not defined: the port and the accumulator are absent. All other behaviour is identical.

## Structure
- Shared package ss_pkg holds:
  - the state enum typedef ss_ld_state_e (IDLE, FILL, DRAIN, DONE);
  - the defaults SS_DATA_W, SS_ADDR_ROM, SS_WIN_LEN.
- One sub-module, ss_loader_chksum (accumulator), instantiated only under SS_LOADER_CHKSUM_EN.
- The loader does not instantiate SS_rom_addr. The two are wired side by side at the parent level.

## Test plan
- WIN_LEN=4, ROM[a]=a+0x100, pulse i_start → writes (0,0x100),(1,0x101),(2,0x102),(3,0x103) in cycles 2–5; o_done in cycle 6; o_rom_we high in cycles 1–4 only.
- i_start held high through two windows → second FILL begins exactly one IDLE cycle after o_done; addresses restart at 0.
- i_abort in the 3rd FILL cycle, WIN_LEN=8 → o_rom_we low next cycle, last write has index 1, no o_done, o_busy=0.
- i_start and i_abort together in IDLE → state stays IDLE, no o_rom_we.
- i_rst_n low mid-FILL → all outputs at reset values immediately; the next i_start performs a full clean load.
- SS_LOADER_CHKSUM_EN, WIN_LEN=4, data 0xFFFF each → o_chksum=0x3FFFC at o_done. WIN_LEN=1 → o_chksum equals the single write, with the write in DRAIN.
